// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } uart_arb_state_t;

    localparam logic [7:0] UART_HDR_BASE_DEFAULT = 8'hA0;
    localparam int         UART_CLKS_PER_BIT     = 50_000_000 / 9600;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_pick
// Brief    : Combinational round-robin picker, first request after `last`.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    // Doubling the request vector turns the wrap-around search into a
    // linear one over the window (last, last+NUM_REQ].
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_mask;

    assign w_dbl = {req, req};

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < 2*NUM_REQ; k++) begin
            w_mask[k] = (k > int'(last)) && (k <= int'(last) + NUM_REQ);
        end
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 2*NUM_REQ-1; k >= 0; k--) begin
            if (w_dbl[k] && w_mask[k]) begin
                found = 1'b1;
                idx   = IDW'(k % NUM_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-level round-robin sharing of one uart_tx, with source
//            header byte and mid-packet stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [7:0]  HDR_BASE       = UART_HDR_BASE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    localparam int         IDW            = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    uart_arb_state_t   r_state;
    uart_arb_state_t   w_state_nxt;
    logic [IDW-1:0]    r_last;
    logic [IDW-1:0]    w_last_nxt;
    logic [IDW-1:0]    r_grant;
    logic [IDW-1:0]    w_grant_nxt;
    logic [c_WD_W-1:0] r_wd;
    logic [c_WD_W-1:0] w_wd_nxt;
    logic [7:0]        r_err;
    logic [7:0]        w_err_nxt;

    logic              w_found;
    logic [IDW-1:0]    w_pick;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [7:0]        w_sel_data;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .last  (r_last),
        .found (w_found),
        .idx   (w_pick)
    );

    assign w_sel_valid = req_valid[r_grant];
    assign w_sel_last  = req_last[r_grant];
    assign w_sel_data  = req_data[{r_grant, 3'b000} +: 8];

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_wd_nxt    = r_wd;
        w_err_nxt   = r_err;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        req_ready   = '0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BASE | 8'(r_grant);
                if (tx_ready) begin
                    w_state_nxt = PAY;
                    w_wd_nxt    = '0;
                end
            end
            PAY: begin
                tx_valid           = w_sel_valid;
                tx_data            = w_sel_data;
                req_ready[r_grant] = tx_ready;
                if (w_sel_valid && tx_ready) begin
                    w_wd_nxt = '0;
                    if (w_sel_last) begin
                        w_last_nxt  = r_grant;
                        w_state_nxt = IDLE;
                    end
                end else if (!w_sel_valid) begin
                    // Only a silent source counts as a stall; a slow UART does not.
                    if (r_wd == c_WD_LAST) begin
                        w_last_nxt  = r_grant;
                        w_state_nxt = IDLE;
                        if (r_err != 8'hFF) begin
                            w_err_nxt = r_err + 8'd1;
                        end
                    end else begin
                        w_wd_nxt = r_wd + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= IDW'(NUM_REQ - 1);
            r_grant <= '0;
            r_wd    <= '0;
            r_err   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_wd    <= w_wd_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign grant_id  = r_grant;
    assign busy      = (r_state != IDLE);
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_N     = 4;
    localparam int c_TO    = 8;
    localparam int c_DEPTH = 512;

    logic             clk;
    logic             rst;
    logic [8*c_N-1:0] req_data;
    logic [c_N-1:0]   req_valid;
    logic [c_N-1:0]   req_last;
    logic [c_N-1:0]   req_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic [7:0]       err_count;

    uart_tx_arbiter #(
        .NUM_REQ        (c_N),
        .HDR_BASE       (8'hA0),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Producer byte stores: {last, data}
    logic [8:0] src_mem [c_N][c_DEPTH];
    int         src_head [c_N];
    int         src_tail [c_N];
    bit         mid_pkt [c_N];
    int         stall_cnt [c_N];
    int         rdy_pulses [c_N];

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         model_last;

    int  cycle = 0;
    int  tx_mode = 0;
    bit  stall_en = 1'b0;
    bit  gap_chk = 1'b0;
    int  last_end_cyc = -1;
    int  end_cyc = -100;
    logic busy_after_end = 1'b1;

    logic       s_tx_valid;
    logic [7:0] s_tx_data;
    logic       s_busy;
    logic [7:0] s_err;
    logic [1:0] s_grant;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input bit l);
        src_mem[i][src_tail[i]] = {l, d};
        src_tail[i]++;
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < c_N; i++) begin
            if (src_head[i] < src_tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < c_N; i++) begin
            src_head[i]   = 0;
            src_tail[i]   = 0;
            mid_pkt[i]    = 1'b0;
            stall_cnt[i]  = 0;
            rdy_pulses[i] = 0;
        end
        obs_q.delete();
        exp_q.delete();
        last_end_cyc = -1;
        end_cyc      = -100;
        stall_en     = 1'b0;
        gap_chk      = 1'b0;
        tx_mode      = 0;
    endtask

    // Packet-level reference: round-robin over requesters that still hold packets.
    task automatic build_expected(input int start_last);
        int   head [c_N];
        int   lst;
        int   i;
        bit   any;
        logic [8:0] e;
        exp_q.delete();
        for (int k = 0; k < c_N; k++) head[k] = src_head[k];
        lst = start_last;
        do begin
            any = 1'b0;
            for (int k = 1; k <= c_N; k++) begin
                i = (lst + k) % c_N;
                if (!any && head[i] < src_tail[i]) begin
                    any = 1'b1;
                    exp_q.push_back(8'hA0 + 8'(i));
                    do begin
                        e = src_mem[i][head[i]];
                        head[i]++;
                        exp_q.push_back(e[7:0]);
                    end while (!e[8] && head[i] < src_tail[i]);
                    lst = i;
                end
            end
        end while (any);
        model_last = lst;
    endtask

    task automatic compare_obs(input string tag);
        int n;
        check_val({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) check_val(tag, obs_q[k], exp_q[k]);
    endtask

    // One clock: drive after the edge, sample on the falling edge.
    task automatic step();
        bit         have;
        bit         stall;
        logic [8:0] e;
        for (int i = 0; i < c_N; i++) begin
            have  = (src_head[i] < src_tail[i]);
            stall = 1'b0;
            if (have && stall_en && mid_pkt[i] && stall_cnt[i] < 5 && $urandom_range(3) == 0) begin
                stall = 1'b1;
                stall_cnt[i]++;
            end
            e = have ? src_mem[i][src_head[i]] : 9'h0;
            req_valid[i]       = have && !stall;
            req_last[i]        = e[8];
            req_data[8*i +: 8] = have ? e[7:0] : 8'($urandom);
        end
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(9) < 6);
            2:       tx_ready = (cycle % 10 == 9);
            default: tx_ready = 1'b0;
        endcase

        @(negedge clk);
        cycle++;
        s_tx_valid = tx_valid;
        s_tx_data  = tx_data;
        s_busy     = busy;
        s_err      = err_count;
        s_grant    = grant_id;
        if (cycle == end_cyc + 1) busy_after_end = busy;
        if (tx_valid && tx_ready) begin
            if (gap_chk && last_end_cyc >= 0) begin
                check_val("pkt_gap", cycle - last_end_cyc, 2);
                last_end_cyc = -1;
            end
            obs_q.push_back(tx_data);
        end
        if (req_ready != '0) check_val("rdy_onehot", $countones(req_ready), 1);
        for (int i = 0; i < c_N; i++) begin
            if (req_ready[i]) rdy_pulses[i]++;
            if (req_ready[i] && req_valid[i]) begin
                e = src_mem[i][src_head[i]];
                check_val("pay_data", {tx_valid, tx_data}, {1'b1, e[7:0]});
                src_head[i]++;
                stall_cnt[i] = 0;
                mid_pkt[i]   = !e[8];
                if (e[8]) begin
                    end_cyc      = cycle;
                    last_end_cyc = cycle;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((!sources_empty() || busy) && n < budget) begin
            step();
            n++;
        end
        check_val("drain_done", (n < budget), 1);
    endtask

    task automatic wait_obs(input int cnt, input int budget);
        int n;
        n = 0;
        while (obs_q.size() < cnt && n < budget) begin
            step();
            n++;
        end
        check_val("wait_obs", (obs_q.size() >= cnt), 1);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        clear_all();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] hold;
        bit         stable;
        int         np;
        int         len;

        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        clear_all();
        #25;
        check_val("rst_tx_valid", tx_valid, 0);
        check_val("rst_tx_data", tx_data, 0);
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_grant", grant_id, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", err_count, 0);

        // Single requester with a slow, pulsing UART
        do_reset();
        tx_mode = 2;
        push_byte(2, 8'h55, 1'b0);
        push_byte(2, 8'h33, 1'b1);
        build_expected(3);
        step();
        check_val("lat_idle", s_tx_valid, 0);
        step();
        check_val("lat_hdr", {s_tx_valid, s_tx_data}, {1'b1, 8'hA2});
        drain(200);
        step();
        compare_obs("single");
        check_val("single_rdy_pulses", rdy_pulses[2], 2);
        check_val("single_busy_drop", busy_after_end, 0);

        // Round-robin across all requesters
        do_reset();
        gap_chk = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < c_N; i++) push_byte(i, 8'h10 + 8'(i), 1'b1);
        build_expected(3);
        drain(300);
        compare_obs("rr");

        // Back-to-back multi-byte packets from two requesters
        do_reset();
        gap_chk = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 3; b++) push_byte(1, 8'h40 + 8'(4*r + b), b == 2);
            for (int b = 0; b < 3; b++) push_byte(3, 8'h80 + 8'(4*r + b), b == 2);
        end
        build_expected(3);
        drain(300);
        compare_obs("b2b");

        // Stall watchdog: source 0 goes silent after one non-last byte
        do_reset();
        push_byte(0, 8'h5A, 1'b0);
        push_byte(1, 8'h11, 1'b1);
        wait_obs(2, 50);
        repeat (c_TO) step();
        check_val("wd_not_yet", s_busy, 1);
        step();
        check_val("wd_abort_idle", s_busy, 0);
        check_val("wd_err_one", s_err, 1);
        drain(100);
        exp_q.delete();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'h11);
        compare_obs("wd");
        check_val("wd_next_grant", grant_id, 1);

        // Slow UART: tx_ready held low with data pending must not time out
        do_reset();
        push_byte(2, 8'hAA, 1'b0);
        push_byte(2, 8'hBB, 1'b0);
        push_byte(2, 8'hCC, 1'b1);
        build_expected(3);
        wait_obs(1, 20);
        tx_mode = 3;
        step();
        hold   = s_tx_data;
        stable = 1'b1;
        repeat (499) begin
            step();
            if (s_tx_data != hold || !s_busy || !s_tx_valid) stable = 1'b0;
        end
        check_val("slow_stable", stable, 1);
        check_val("slow_data", hold, 8'hAA);
        check_val("slow_no_err", s_err, 0);
        tx_mode = 0;
        drain(100);
        compare_obs("slow");

        // Forced aborts saturate the error counter
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            push_byte(0, 8'(n), 1'b0);
            drain(40);
            if (n == 100) check_val("err_100", err_count, 100);
        end
        check_val("err_saturate", err_count, 255);

        // Asynchronous reset in the middle of a payload
        obs_q.delete();
        push_byte(1, 8'h71, 1'b0);
        push_byte(1, 8'h72, 1'b0);
        push_byte(1, 8'h73, 1'b1);
        wait_obs(2, 30);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_tx_valid", tx_valid, 0);
        check_val("mid_rst_tx_data", tx_data, 0);
        check_val("mid_rst_req_ready", req_ready, 0);
        check_val("mid_rst_grant", grant_id, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_err", err_count, 0);
        clear_all();
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push_byte(2, 8'h12, 1'b1);
        push_byte(0, 8'h10, 1'b1);
        build_expected(3);
        drain(100);
        compare_obs("post_rst");

        // Randomized traffic with short producer stalls and a random UART
        do_reset();
        stall_en   = 1'b1;
        tx_mode    = 1;
        model_last = 3;
        for (int it = 0; it < 4; it++) begin
            obs_q.delete();
            for (int i = 0; i < c_N; i++) begin
                np = $urandom_range(3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
                end
            end
            build_expected(model_last);
            drain(2000);
            compare_obs("rand");
            if (exp_q.size() > 0) check_val("rand_grant", grant_id, model_last);
            check_val("rand_no_err", err_count, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters using round-robin arbitration at packet granularity. Each granted packet is prefixed with a header byte identifying its source, so the far-end receiver can demultiplex. A watchdog aborts packets whose source stalls mid-packet. It sits between the on-chip producers and the `valid`/`ready` port of `uart_tx`.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..16.
- `HDR_BASE`, 8'hA0: header byte base; low 4 bits must be 0.
- `TIMEOUT_CYCLES`, 1_000_000: stall cycles tolerated mid-packet before abort; ≥ 2.
- `IDW`, $clog2(NUM_REQ): derived, not overridable.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `req_data`  in  8*NUM_REQ  byte from requester i at bits [8i+7:8i].
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_last`  in  NUM_REQ  byte is the last of its packet.
- `req_ready`  out  NUM_REQ  byte i consumed this cycle.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_valid`  out  1  handshake to `uart_tx`.
- `tx_ready`  in  1  handshake from `uart_tx`.
- `grant_id`  out  IDW  currently or last granted requester.
- `busy`  out  1  high in HDR and PAY.
- `err_count`  out  8  aborted-packet count, saturates at 255.

## Operation
- A transfer occurs on any cycle with valid && ready.
- FSM states: IDLE, HDR, PAY.
- **IDLE:**
  - If any `req_valid` is high, pick the first set bit searching from `last+1` upward, wrapping at `NUM_REQ`.
  - Register the pick into `grant_id` and go to HDR.
  - If no request is pending, stay in IDLE.
- **HDR:**
  - Drive `tx_valid=1` and `tx_data=HDR_BASE | grant_id`. Both are held stable until `tx_ready`.
  - On transfer, go to PAY. No `req_ready` is asserted in HDR.
- **PAY:**
  - Combinational pass-through of the granted requester: `tx_valid=req_valid[g]`, `tx_data=req_data[g]`, `req_ready[g]=tx_ready`. All other `req_ready` stay 0.
  - On a transfer with `req_last[g]=1`: set `last=g` and go to IDLE.
- **Watchdog:**
  - A counter clears on entry to PAY and on every PAY transfer.
  - It increments on PAY cycles where `req_valid[g]=0`.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, set `last=g`, and increment `err_count` (saturating).
  - The counter is not active while `tx_ready` is low with `req_valid` high, because the UART is allowed to be slow.
- Requests from non-granted sources are ignored until the next IDLE.
- Fairness: a requester that keeps `req_valid` high is granted within `NUM_REQ` packets.

## Timing
- Reset values:
  - State IDLE, `last = NUM_REQ-1`, so the first grant goes to requester 0.
  - `tx_valid=0`, `tx_data=0`, `req_ready=0`, `grant_id=0`, `busy=0`, `err_count=0`.
- Reset asserted mid-packet returns to IDLE immediately. The partial packet is discarded and `err_count` is not incremented.
- Grant latency: `req_valid` is sampled in IDLE on edge N; `tx_valid` for the header is asserted after edge N, i.e. one cycle.
- Packet end: after the last-byte transfer at edge M, the FSM is in IDLE. The next header is asserted after edge M+1, so there is one idle cycle between packets.
- In HDR, `tx_valid`/`tx_data` are registered. In PAY they are combinational from the requester inputs.
- A packet consisting of a single byte with `req_last=1` is legal: header followed by one byte.
- `req_last` is only sampled on a PAY transfer.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_arb_state_t` (IDLE, HDR, PAY);
  - `UART_HDR_BASE_DEFAULT`;
  - `UART_CLKS_PER_BIT` (50_000_000/9600).
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs are the request vector and `last`. Outputs are `found` and `idx`. Implement it with a double-width mask.
- Counter, FSM and mux live in `uart_tx_arbiter`.

## Test plan
- **Single requester.** Requester 2 sends 0x55 then 0x33 (last), with `tx_ready` pulsing every 10 cycles.
  - Required: `tx` bytes A2, 55, 33.
  - Required: `req_ready[2]` pulses exactly twice; `busy` drops one cycle after the 0x33 transfer.
- **Round-robin.** All 4 requesters hold one-byte packets (0x10+i, last).
  - Required: header order A0, A1, A2, A3, then A0.
  - Required: each header is followed by its 0x10+i byte.
- **Back-to-back.** Requesters 1 and 3 each send 3-byte packets, repeated.
  - Required: headers alternate A1/A3.
  - Required: exactly one IDLE cycle between packets.
- **Stall timeout.** Use `TIMEOUT_CYCLES=8`. Requester 0 sends one non-last byte, then drops `req_valid`.
  - Required: return to IDLE after 8 stall cycles; `err_count` = 1.
  - Required: requester 1 is granted next.
- **Slow UART.** `tx_ready` is low for 500 cycles while `req_valid` is high.
  - Required: no timeout, and `tx_data` stays stable.
  - A further test drives 300 forced aborts; required: `err_count` saturates at 255.
- **Reset mid-PAY.** Assert `rst` low during a payload byte.
  - Required: all outputs reach their reset values asynchronously and `err_count` = 0.
  - Required: the next grant goes to requester 0.
